// File: rtl/trace_axis_packer.sv
// Packs REC_W-bit trace records into 512-bit AXI-Stream beats; packets close on beat count, flush or idle timeout.
// Optional statistics counters are enabled with `define TRACE_PACK_STATS_EN.
module trace_axis_packer #(
  parameter int REC_W     = 64,
  parameter int PKT_BEATS = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_trace_valid,
  output logic              s_trace_ready,
  input  logic [REC_W-1:0]  s_trace_data,
  input  logic              flush,
  output logic              m_axis_trace_tvalid,
  input  logic              m_axis_trace_tready,
  output logic [511:0]      m_axis_trace_tdata,
  output logic [63:0]       m_axis_trace_tkeep,
  output logic              m_axis_trace_tlast
`ifdef TRACE_PACK_STATS_EN
  ,
  output logic [31:0]       stat_rec_cnt,
  output logic [31:0]       stat_pkt_cnt
`endif
);

  localparam int LANES          = 512 / REC_W;
  localparam int LANE_W         = $clog2(LANES + 1);
  localparam int BYTES_PER_LANE = REC_W / 8;
  localparam int BEAT_W         = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam int TMO_W          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [LANE_W-1:0] LANES_L   = LANE_W'(LANES);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_BEATS - 1);
  localparam logic [TMO_W-1:0]  TMO_HIT   = TMO_W'(TIMEOUT - 1);

  function automatic logic [63:0] lane_keep(input logic [LANE_W-1:0] n);
    logic [63:0] k;
    k = 64'd0;
    for (int i = 0; i < LANES; i++) begin
      if (LANE_W'(i) < n) begin
        k[i*BYTES_PER_LANE +: BYTES_PER_LANE] = {BYTES_PER_LANE{1'b1}};
      end else begin
        k[i*BYTES_PER_LANE +: BYTES_PER_LANE] = {BYTES_PER_LANE{1'b0}};
      end
    end
    return k;
  endfunction

  logic [511:0]       acc_data_r, acc_data_s, fill_data_s;
  logic [LANE_W-1:0]  lane_r, lane_s, fill_lane_s;
  logic               out_valid_r, out_valid_s;
  logic [511:0]       out_data_r, out_data_s;
  logic [63:0]        out_keep_r, out_keep_s;
  logic               out_last_r, out_last_s;
  logic [BEAT_W-1:0]  beat_cnt_r, beat_cnt_s;
  logic [TMO_W-1:0]   tmo_cnt_r, tmo_cnt_s;
  logic               close_pend_r, close_pend_s;
  logic               ready_r, ready_s;
  logic               accept_s, handoff_s, out_free_s, tmo_hit_s, close_s, beat_load_s;

  assign accept_s   = s_trace_valid && ready_r;
  assign handoff_s  = out_valid_r && m_axis_trace_tready;
  assign out_free_s = !out_valid_r || m_axis_trace_tready;
  assign tmo_hit_s  = (TIMEOUT != 0) && (lane_r != LANE_W'(0)) && !accept_s && (tmo_cnt_r == TMO_HIT);
  assign close_s    = flush || tmo_hit_s || close_pend_r;

  // Next-state: accumulate, load beats, resolve close events, run the idle timer.
  always_comb begin
    fill_data_s  = acc_data_r;
    fill_lane_s  = lane_r;
    acc_data_s   = acc_data_r;
    lane_s       = lane_r;
    out_valid_s  = out_valid_r;
    out_data_s   = out_data_r;
    out_keep_s   = out_keep_r;
    out_last_s   = out_last_r;
    beat_cnt_s   = beat_cnt_r;
    tmo_cnt_s    = tmo_cnt_r;
    close_pend_s = 1'b0;
    beat_load_s  = 1'b0;

    if (accept_s) begin
      fill_data_s[lane_r*REC_W +: REC_W] = s_trace_data;
      fill_lane_s = lane_r + LANE_W'(1);
    end else begin
      fill_lane_s = lane_r;
    end
    acc_data_s = fill_data_s;
    lane_s     = fill_lane_s;

    if (handoff_s) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end

    if (close_s) begin
      if (fill_lane_s != LANE_W'(0)) begin
        if (out_free_s) begin
          out_valid_s = 1'b1;
          out_data_s  = fill_data_s;
          out_keep_s  = lane_keep(fill_lane_s);
          out_last_s  = 1'b1;
          beat_cnt_s  = BEAT_W'(0);
          acc_data_s  = 512'd0;
          lane_s      = LANE_W'(0);
          beat_load_s = 1'b1;
        end else begin
          close_pend_s = 1'b1;
        end
      end else if (out_valid_r && !m_axis_trace_tready) begin
        // Stalled beat is still on the bus: only tlast may rise.
        out_last_s = 1'b1;
        beat_cnt_s = BEAT_W'(0);
      end else if (beat_cnt_r != BEAT_W'(0)) begin
        out_valid_s = 1'b1;
        out_data_s  = 512'd0;
        out_keep_s  = 64'd0;
        out_last_s  = 1'b1;
        beat_cnt_s  = BEAT_W'(0);
        beat_load_s = 1'b1;
      end else begin
        beat_cnt_s = beat_cnt_r;
      end
    end else if ((fill_lane_s == LANES_L) && out_free_s) begin
      out_valid_s = 1'b1;
      out_data_s  = fill_data_s;
      out_keep_s  = lane_keep(LANES_L);
      out_last_s  = (beat_cnt_r == LAST_BEAT);
      beat_cnt_s  = (beat_cnt_r == LAST_BEAT) ? BEAT_W'(0) : beat_cnt_r + BEAT_W'(1);
      acc_data_s  = 512'd0;
      lane_s      = LANE_W'(0);
      beat_load_s = 1'b1;
    end else begin
      beat_load_s = 1'b0;
    end

    if (accept_s || close_s || beat_load_s) begin
      tmo_cnt_s = TMO_W'(0);
    end else if (lane_r != LANE_W'(0)) begin
      tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_s = TMO_W'(0);
    end

    ready_s = (lane_s != LANES_L) && !close_pend_s;
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_data_r   <= 512'd0;
      lane_r       <= LANE_W'(0);
      out_valid_r  <= 1'b0;
      out_data_r   <= 512'd0;
      out_keep_r   <= 64'd0;
      out_last_r   <= 1'b0;
      beat_cnt_r   <= BEAT_W'(0);
      tmo_cnt_r    <= TMO_W'(0);
      close_pend_r <= 1'b0;
      ready_r      <= 1'b0;
    end else begin
      acc_data_r   <= acc_data_s;
      lane_r       <= lane_s;
      out_valid_r  <= out_valid_s;
      out_data_r   <= out_data_s;
      out_keep_r   <= out_keep_s;
      out_last_r   <= out_last_s;
      beat_cnt_r   <= beat_cnt_s;
      tmo_cnt_r    <= tmo_cnt_s;
      close_pend_r <= close_pend_s;
      ready_r      <= ready_s;
    end
  end

  assign s_trace_ready       = ready_r;
  assign m_axis_trace_tvalid = out_valid_r;
  assign m_axis_trace_tdata  = out_data_r;
  assign m_axis_trace_tkeep  = out_keep_r;
  assign m_axis_trace_tlast  = out_last_r;

`ifdef TRACE_PACK_STATS_EN
  logic [31:0] rec_cnt_r, pkt_cnt_r;

  // Accepted-record and completed-packet counters, free-running with wrap.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rec_cnt_r <= 32'd0;
      pkt_cnt_r <= 32'd0;
    end else begin
      rec_cnt_r <= rec_cnt_r + (accept_s ? 32'd1 : 32'd0);
      pkt_cnt_r <= pkt_cnt_r + ((handoff_s && out_last_r) ? 32'd1 : 32'd0);
    end
  end

  assign stat_rec_cnt = rec_cnt_r;
  assign stat_pkt_cnt = pkt_cnt_r;
`endif

endmodule

// File: tb/tb_trace_axis_packer.sv
// Directed self-checking bench for trace_axis_packer.
module tb_trace_axis_packer;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         s_trace_valid = 1'b0;
  logic         s_trace_ready;
  logic [63:0]  s_trace_data = 64'd0;
  logic         flush = 1'b0;
  logic         m_axis_trace_tvalid;
  logic         m_axis_trace_tready = 1'b1;
  logic [511:0] m_axis_trace_tdata;
  logic [63:0]  m_axis_trace_tkeep;
  logic         m_axis_trace_tlast;

  logic         valid2 = 1'b0;
  logic         mirror = 1'b0;
  logic         ready2, tvalid2, tlast2;
  logic [511:0] tdata2;
  logic [63:0]  tkeep2;
`ifdef TRACE_PACK_STATS_EN
  logic [31:0]  stat_rec_cnt, stat_pkt_cnt, stat_rec2, stat_pkt2;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [511:0] q_data[$];
  logic [63:0]  q_keep[$];
  logic         q_last[$];
  logic         prev_stall = 1'b0;
  logic [511:0] prev_data = 512'd0;
  logic [63:0]  prev_keep = 64'd0;
  logic         prev_last = 1'b0;
  logic         dut2_seen = 1'b0;

  always #5 aclk = ~aclk;

  trace_axis_packer u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_trace_valid(s_trace_valid), .s_trace_ready(s_trace_ready), .s_trace_data(s_trace_data),
    .flush(flush),
    .m_axis_trace_tvalid(m_axis_trace_tvalid), .m_axis_trace_tready(m_axis_trace_tready),
    .m_axis_trace_tdata(m_axis_trace_tdata), .m_axis_trace_tkeep(m_axis_trace_tkeep),
    .m_axis_trace_tlast(m_axis_trace_tlast)
`ifdef TRACE_PACK_STATS_EN
    , .stat_rec_cnt(stat_rec_cnt), .stat_pkt_cnt(stat_pkt_cnt)
`endif
  );

  trace_axis_packer #(.TIMEOUT(0)) u_dut_nt (
    .aclk(aclk), .aresetn(aresetn),
    .s_trace_valid(valid2), .s_trace_ready(ready2), .s_trace_data(s_trace_data),
    .flush(1'b0),
    .m_axis_trace_tvalid(tvalid2), .m_axis_trace_tready(1'b1),
    .m_axis_trace_tdata(tdata2), .m_axis_trace_tkeep(tkeep2),
    .m_axis_trace_tlast(tlast2)
`ifdef TRACE_PACK_STATS_EN
    , .stat_rec_cnt(stat_rec2), .stat_pkt_cnt(stat_pkt2)
`endif
  );

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [63:0] d);
    int waited;
    waited = 0;
    s_trace_data  = d;
    s_trace_valid = 1'b1;
    valid2        = mirror;
    while (!s_trace_ready && waited < 500) begin
      step();
      waited++;
    end
    check("push_ready", 640'(s_trace_ready), 640'd1);
    step();
    s_trace_valid = 1'b0;
    valid2        = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_keep.delete();
    q_last.delete();
  endtask

  function automatic logic [511:0] beat_of(input logic [63:0] base, input int n);
    logic [511:0] b;
    b = 512'd0;
    for (int l = 0; l < n; l++) b[l*64 +: 64] = base + 64'(l);
    return b;
  endfunction

  // Beat capture, hold-stability check while stalled, and watch on the no-timeout instance.
  always @(negedge aclk) begin
    if (aresetn && m_axis_trace_tvalid && m_axis_trace_tready) begin
      q_data.push_back(m_axis_trace_tdata);
      q_keep.push_back(m_axis_trace_tkeep);
      q_last.push_back(m_axis_trace_tlast);
    end
    if (aresetn && prev_stall) begin
      check("hold_stable",
            640'({m_axis_trace_tvalid, m_axis_trace_tdata, m_axis_trace_tkeep, (m_axis_trace_tlast | ~prev_last)}),
            640'({1'b1, prev_data, prev_keep, 1'b1}));
    end
    prev_stall <= aresetn && m_axis_trace_tvalid && !m_axis_trace_tready;
    prev_data  <= m_axis_trace_tdata;
    prev_keep  <= m_axis_trace_tkeep;
    prev_last  <= m_axis_trace_tlast;
    if (tvalid2) dut2_seen <= 1'b1;
  end

  initial begin
    int steps;
    int lasts;
    int stall_ready;

    // Reset state
    repeat (3) step();
    check("rst_ready", 640'(s_trace_ready), 640'd0);
    check("rst_out", 640'({m_axis_trace_tvalid, m_axis_trace_tdata, m_axis_trace_tkeep, m_axis_trace_tlast}), 640'd0);
    aresetn = 1'b1;
    step();
    check("rel_ready", 640'(s_trace_ready), 640'd1);

    // Contiguous stream of 128 records, tready held high
    clear_q();
    for (int i = 0; i < 128; i++) begin
      if (i == 7) check("A_no_early_tvalid", 640'(m_axis_trace_tvalid), 640'd0);
      push(64'(i));
      if (i == 7) check("A_first_tvalid", 640'(m_axis_trace_tvalid), 640'd1);
    end
    repeat (3) step();
    check("A_beats", 640'(q_data.size()), 640'd16);
    if (q_data.size() == 16) begin
      check("A_b0_lane0", 640'(q_data[0][63:0]), 640'd0);
      check("A_b0_lane7", 640'(q_data[0][511:448]), 640'd7);
      lasts = 0;
      for (int b = 0; b < 16; b++) begin
        check("A_data", 640'(q_data[b]), 640'(beat_of(64'(b * 8), 8)));
        check("A_keep", 640'(q_keep[b]), 640'(64'hFFFF_FFFF_FFFF_FFFF));
        lasts += int'(q_last[b]);
      end
      check("A_last15", 640'(q_last[15]), 640'd1);
      check("A_last_count", 640'(lasts), 640'd1);
    end

    // Three records then flush
    clear_q();
    push(64'hA0); push(64'hA1); push(64'hA2);
    pulse_flush();
    repeat (3) step();
    check("B_beats", 640'(q_data.size()), 640'd1);
    if (q_data.size() == 1) begin
      check("B_keep", 640'(q_keep[0]), 640'(64'h0000_0000_00FF_FFFF));
      check("B_last", 640'(q_last[0]), 640'd1);
      check("B_data", 640'(q_data[0]), 640'(beat_of(64'hA0, 3)));
    end

    // Idle timeout with five records; the TIMEOUT=0 instance sees the same records
    clear_q();
    mirror = 1'b1;
    for (int i = 0; i < 5; i++) push(64'hB0 + 64'(i));
    mirror = 1'b0;
    steps = 0;
    while (!m_axis_trace_tvalid && steps < 1200) begin
      step();
      steps++;
    end
    check("C_latency_window", 640'(steps >= 1023 && steps <= 1025), 640'd1);
    repeat (2) step();
    check("C_beats", 640'(q_data.size()), 640'd1);
    if (q_data.size() == 1) begin
      check("C_keep", 640'(q_keep[0]), 640'(64'h0000_00FF_FFFF_FFFF));
      check("C_last", 640'(q_last[0]), 640'd1);
      check("C_data", 640'(q_data[0]), 640'(beat_of(64'hB0, 5)));
    end
    repeat (200) step();
    check("C_no_timeout_beat", 640'(dut2_seen), 640'd0);

    // Back-pressure: 200 stalled cycles under continuous input
    clear_q();
    m_axis_trace_tready = 1'b0;
    for (int i = 0; i < 16; i++) push(64'h100 + 64'(i));
    check("D_ready_low", 640'(s_trace_ready), 640'd0);
    check("D_tvalid", 640'(m_axis_trace_tvalid), 640'd1);
    s_trace_valid = 1'b1;
    s_trace_data  = 64'h110;
    stall_ready = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      stall_ready += int'(s_trace_ready);
    end
    check("D_ready_stays_low", 640'(stall_ready), 640'd0);
    m_axis_trace_tready = 1'b1;
    for (int i = 16; i < 32; i++) push(64'h100 + 64'(i));
    repeat (3) step();
    check("D_beats", 640'(q_data.size()), 640'd4);
    if (q_data.size() == 4) begin
      for (int b = 0; b < 4; b++) begin
        check("D_data", 640'(q_data[b]), 640'(beat_of(64'h100 + 64'(b * 8), 8)));
        check("D_last", 640'(q_last[b]), 640'd0);
      end
    end

    // Flush against a stalled full beat: tlast is raised, no null beat
    clear_q();
    m_axis_trace_tready = 1'b0;
    for (int i = 0; i < 8; i++) push(64'h200 + 64'(i));
    check("E_pre_last", 640'(m_axis_trace_tlast), 640'd0);
    pulse_flush();
    check("E_set_last", 640'({m_axis_trace_tvalid, m_axis_trace_tlast}), 640'd3);
    step();
    m_axis_trace_tready = 1'b1;
    repeat (4) step();
    check("E_beats", 640'(q_data.size()), 640'd1);
    if (q_data.size() == 1) begin
      check("E_data", 640'(q_data[0]), 640'(beat_of(64'h200, 8)));
      check("E_last", 640'(q_last[0]), 640'd1);
    end

    // Flush with empty register and open packet: null beat
    clear_q();
    for (int i = 0; i < 8; i++) push(64'h300 + 64'(i));
    repeat (2) step();
    pulse_flush();
    repeat (3) step();
    check("N_beats", 640'(q_data.size()), 640'd2);
    if (q_data.size() == 2) begin
      check("N_b0_last", 640'(q_last[0]), 640'd0);
      check("N_null", 640'({q_data[1], q_keep[1], q_last[1]}), 640'd1);
    end
    pulse_flush();
    repeat (3) step();
    check("N_noop_flush", 640'(q_data.size()), 640'd2);

    // Flush in the same cycle as the record filling the last lane
    clear_q();
    for (int i = 0; i < 7; i++) push(64'h400 + 64'(i));
    flush = 1'b1;
    push(64'h407);
    flush = 1'b0;
    repeat (3) step();
    check("G_beats", 640'(q_data.size()), 640'd1);
    if (q_data.size() == 1) begin
      check("G_beat", 640'({q_data[0], q_keep[0], q_last[0]}),
            640'({beat_of(64'h400, 8), 64'hFFFF_FFFF_FFFF_FFFF, 1'b1}));
    end

    // Reset with a stalled beat and four buffered records
    m_axis_trace_tready = 1'b0;
    for (int i = 0; i < 12; i++) push(64'h500 + 64'(i));
    check("F_pre_tvalid", 640'(m_axis_trace_tvalid), 640'd1);
    aresetn = 1'b0;
    #1;
    check("F_rst_ready", 640'(s_trace_ready), 640'd0);
    check("F_rst_out", 640'({m_axis_trace_tvalid, m_axis_trace_tdata, m_axis_trace_tkeep, m_axis_trace_tlast}), 640'd0);
    repeat (2) step();
    m_axis_trace_tready = 1'b1;
    aresetn = 1'b1;
    step();
    clear_q();
    for (int i = 0; i < 8; i++) push(64'h600 + 64'(i));
    repeat (3) step();
    check("F_beats", 640'(q_data.size()), 640'd1);
    if (q_data.size() == 1) begin
      check("F_beat", 640'({q_data[0], q_keep[0], q_last[0]}),
            640'({beat_of(64'h600, 8), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0}));
    end
`ifdef TRACE_PACK_STATS_EN
    check("F_stat_rec", 640'(stat_rec_cnt), 640'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
